// File: rtl/code_mem_pkg.sv
// code_mem_pkg: shared instruction encodings and load/fetch state encoding for code_mem.
package code_mem_pkg;
  localparam logic [3:0] OP_NOP = 4'hF;
  localparam logic [2:0] R_ZERO = 3'd0;
  localparam logic [6:0] NOP_HI = {OP_NOP, R_ZERO};
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/code_mem_array.sv
// code_mem_array: instruction storage, one write port and one registered read port.
// Optional even-parity bit per slot when CODE_MEM_PARITY_EN is defined.
module code_mem_array #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
`ifdef CODE_MEM_PARITY_EN
  , output logic        perr
`endif
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
`ifdef CODE_MEM_PARITY_EN
  logic par_mem [DEPTH];
  logic par_q;
  always_ff @(posedge clk) begin
    if (we) par_mem[waddr] <= ^wdata;
    if (re) par_q <= par_mem[raddr];
  end
  assign perr = ^{par_q, rdata_q};
`endif
endmodule

// File: rtl/code_mem.sv
// code_mem: loadable instruction memory with EMPTY/LOAD/RUN control and 1-cycle fetch.
// Optional parity checking enabled by defining CODE_MEM_PARITY_EN (adds par_err port).
module code_mem
  import code_mem_pkg::*;
#(
  parameter int INSWIDTH = 16,
  parameter int PCWIDTH  = 8,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_start,
  input  logic                ld_valid,
  input  logic                ld_last,
  input  logic [INSWIDTH-1:0] ld_data,
  output logic                ld_ready,
  input  logic                fe_req,
  input  logic [PCWIDTH-1:0]  fe_pc,
  output logic                fe_valid,
  output logic [INSWIDTH-1:0] fe_ins,
  output logic                busy,
  output logic [PCWIDTH:0]    prog_len
`ifdef CODE_MEM_PARITY_EN
  , output logic              par_err
`endif
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [INSWIDTH-1:0] NOP = {NOP_HI, {(INSWIDTH-$bits(NOP_HI)){1'b0}}};
  localparam logic [PCWIDTH:0] LEN_MAX = (PCWIDTH+1)'(DEPTH);
  state_t state_q, state_d;
  logic [PCWIDTH:0] wptr_q, wptr_d, len_q, len_d;
  logic fe_valid_q, fe_valid_d, sel_q, sel_d;
  logic we, done, hit;
  logic [INSWIDTH-1:0] rdata;
  assign ld_ready = (state_q == ST_LOAD) && (wptr_q < LEN_MAX);
  // a word arriving with ld_start is discarded: the restart wins
  assign we   = ld_valid && ld_ready && !ld_start;
  assign done = we && (ld_last || wptr_q == LEN_MAX - 1'b1);
  assign hit  = fe_req && (state_q == ST_RUN) && ({1'b0, fe_pc} < len_q);
  always_comb begin
    state_d    = ld_start ? ST_LOAD : done ? ST_RUN : state_q;
    wptr_d     = ld_start ? '0 : we ? wptr_q + 1'b1 : wptr_q;
    len_d      = ld_start ? '0 : done ? wptr_q + 1'b1 : len_q;
    fe_valid_d = fe_req;
    sel_d      = fe_req ? hit : sel_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wptr_q     <= '0;
      len_q      <= '0;
      fe_valid_q <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      len_q      <= len_d;
      fe_valid_q <= fe_valid_d;
      sel_q      <= sel_d;
    end
  end
  assign fe_valid = fe_valid_q;
  assign busy     = (state_q == ST_LOAD);
  assign prog_len = len_q;
`ifdef CODE_MEM_PARITY_EN
  logic perr;
  code_mem_array #(.W(INSWIDTH), .DEPTH(DEPTH), .IW(IW)) u_arr (
    .clk(clk), .we(we), .waddr(wptr_q[IW-1:0]), .wdata(ld_data),
    .re(hit), .raddr(fe_pc[IW-1:0]), .rdata(rdata), .perr(perr)
  );
  assign fe_ins  = (sel_q && !perr) ? rdata : NOP;
  assign par_err = fe_valid_q && sel_q && perr;
`else
  code_mem_array #(.W(INSWIDTH), .DEPTH(DEPTH), .IW(IW)) u_arr (
    .clk(clk), .we(we), .waddr(wptr_q[IW-1:0]), .wdata(ld_data),
    .re(hit), .raddr(fe_pc[IW-1:0]), .rdata(rdata)
  );
  assign fe_ins = sel_q ? rdata : NOP;
`endif
endmodule

// File: tb/tb_code_mem.sv
// tb_code_mem: randomized self-checking bench for code_mem against a queue-based program model.
module tb_code_mem;
  import code_mem_pkg::*;
  localparam int W = 16, PW = 8, D = 8;
  localparam logic [W-1:0] NOP = {OP_NOP, R_ZERO, 9'b0};
  logic clk = 0, rst_n = 0;
  logic ld_start = 0, ld_valid = 0, ld_last = 0, fe_req = 0;
  logic [W-1:0] ld_data = '0;
  logic [PW-1:0] fe_pc = '0;
  logic ld_ready, fe_valid, busy;
  logic [W-1:0] fe_ins;
  logic [PW:0] prog_len;
`ifdef CODE_MEM_PARITY_EN
  logic par_err;
`endif
  code_mem #(.INSWIDTH(W), .PCWIDTH(PW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_last(ld_last), .ld_data(ld_data), .ld_ready(ld_ready), .fe_req(fe_req),
    .fe_pc(fe_pc), .fe_valid(fe_valid), .fe_ins(fe_ins), .busy(busy),
    .prog_len(prog_len)
`ifdef CODE_MEM_PARITY_EN
    , .par_err(par_err)
`endif
  );
  always #5 clk = ~clk;
  wire [27:0] got = {fe_valid, fe_ins, prog_len, busy, ld_ready};
  bit loading = 0, running = 0, ev = 0;
  logic [W-1:0] ei = NOP;
  logic [W-1:0] prog[$], lq[$];
  int n_pass = 0, n_chk = 0;
  function automatic logic [27:0] model_out();
    return {ev, ei, 9'(prog.size()), loading, loading && (lq.size() < D)};
  endfunction
  task automatic cycle(input bit s, v, l, input logic [W-1:0] d, input bit r, input logic [PW-1:0] pc);
    bit rdy;
    ld_start = s; ld_valid = v; ld_last = l; ld_data = d; fe_req = r; fe_pc = pc;
    @(posedge clk);
    rdy = loading && (lq.size() < D);
    if (r) begin
      ev = 1;
      ei = (running && pc < prog.size()) ? prog[pc] : NOP;
    end else ev = 0;
    if (s) begin
      loading = 1; running = 0; prog.delete(); lq.delete();
    end else if (v && rdy) begin
      lq.push_back(d);
      if (l || lq.size() == D) begin
        prog = lq; loading = 0; running = 1;
      end
    end
    #1;
    ld_start = 0; ld_valid = 0; ld_last = 0; fe_req = 0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (got !== {1'b0, NOP, 9'd0, 1'b0, 1'b0}) $display("FAIL reset_state: got %h exp %h", got, {1'b0, NOP, 9'd0, 2'b00});
    else n_pass++;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_basic();
    logic [W-1:0] words [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [PW-1:0] pcs [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd200};
    logic [W-1:0] exps [5] = '{16'h1111, 16'h2222, 16'h3333, NOP, NOP};
    cycle(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, i == 2, words[i], 0, 0);
    n_chk++;
    if (prog_len !== 9'd3 || busy !== 1'b0 || ld_ready !== 1'b0) $display("FAIL basic_len: got len=%0d busy=%b rdy=%b exp len=3 busy=0 rdy=0", prog_len, busy, ld_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, '0, 1, pcs[i]);
      n_chk++;
      if (fe_valid !== 1'b1 || fe_ins !== exps[i]) $display("FAIL basic_fetch pc=%0d: got v=%b ins=%h exp v=1 ins=%h", pcs[i], fe_valid, fe_ins, exps[i]);
      else n_pass++;
    end
    cycle(0, 0, 0, '0, 0, 0);
    n_chk++;
    if (fe_valid !== 1'b0 || fe_ins !== NOP) $display("FAIL basic_hold: got v=%b ins=%h exp v=0 ins=%h", fe_valid, fe_ins, NOP);
    else n_pass++;
  endtask
  task automatic test_full();
    cycle(1, 0, 0, '0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, W'($urandom), 0, 0);
      n_chk++;
      if (got !== model_out()) $display("FAIL full_word%0d: got %h exp %h", i, got, model_out());
      else n_pass++;
    end
    n_chk++;
    if (prog_len !== 9'd8 || ld_ready !== 1'b0 || busy !== 1'b0) $display("FAIL full_end: got len=%0d rdy=%b busy=%b exp len=8 rdy=0 busy=0", prog_len, ld_ready, busy);
    else n_pass++;
    cycle(0, 0, 0, '0, 1, 7);
    n_chk++;
    if (got !== model_out()) $display("FAIL full_fetch7: got %h exp %h", got, model_out());
    else n_pass++;
  endtask
  task automatic test_start_priority();
    logic [W-1:0] old = prog[1];
    cycle(1, 0, 0, '0, 1, 1);
    n_chk++;
    if (fe_valid !== 1'b1 || fe_ins !== old || busy !== 1'b1) $display("FAIL start_old_word: got v=%b ins=%h busy=%b exp v=1 ins=%h busy=1", fe_valid, fe_ins, busy, old);
    else n_pass++;
    cycle(0, 1, 0, W'($urandom), 1, 1);
    n_chk++;
    if (fe_ins !== NOP || busy !== 1'b1 || prog_len !== 9'd0) $display("FAIL load_fetch: got ins=%h busy=%b len=%0d exp ins=%h busy=1 len=0", fe_ins, busy, prog_len, NOP);
    else n_pass++;
    cycle(1, 1, 1, 16'hDEAD, 0, 0);
    cycle(0, 1, 1, 16'h4444, 0, 0);
    cycle(0, 0, 0, '0, 1, 0);
    n_chk++;
    if (fe_ins !== 16'h4444 || prog_len !== 9'd1) $display("FAIL start_discard: got ins=%h len=%0d exp ins=4444 len=1", fe_ins, prog_len);
    else n_pass++;
  endtask
  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(19) == 0, $urandom_range(3) != 0, $urandom_range(5) == 0, W'($urandom),
            $urandom_range(1) == 1, ($urandom_range(9) == 0) ? PW'($urandom) : PW'($urandom_range(11)));
      n_chk++;
      if (got !== model_out()) begin
        bad++;
        if (bad <= 5) $display("FAIL random_cycle%0d: got %h exp %h", i, got, model_out());
      end else n_pass++;
    end
  endtask
  task automatic test_reset_midload();
    cycle(1, 0, 0, '0, 0, 0);
    cycle(0, 1, 0, 16'hAAAA, 0, 0);
    cycle(0, 1, 0, 16'hBBBB, 0, 0);
    #2 rst_n = 0;
    #1;
    n_chk++;
    if (got !== {1'b0, NOP, 9'd0, 1'b0, 1'b0}) $display("FAIL async_reset: got %h exp %h", got, {1'b0, NOP, 9'd0, 2'b00});
    else n_pass++;
    @(negedge clk) rst_n = 1;
    loading = 0; running = 0; prog.delete(); lq.delete(); ev = 0; ei = NOP;
    cycle(0, 1, 1, 16'hCCCC, 1, 0);
    n_chk++;
    if (fe_valid !== 1'b1 || fe_ins !== NOP || busy !== 1'b0 || prog_len !== 9'd0) $display("FAIL reset_fetch: got v=%b ins=%h busy=%b len=%0d exp v=1 ins=%h busy=0 len=0", fe_valid, fe_ins, busy, prog_len, NOP);
    else n_pass++;
  endtask
`ifdef CODE_MEM_PARITY_EN
  task automatic test_parity();
    cycle(1, 0, 0, '0, 0, 0);
    cycle(0, 1, 0, 16'h1234, 0, 0);
    cycle(0, 1, 1, 16'h5678, 0, 0);
    dut.u_arr.mem[1] = dut.u_arr.mem[1] ^ 16'h0001;
    cycle(0, 0, 0, '0, 1, 1);
    n_chk++;
    if (par_err !== 1'b1 || fe_ins !== NOP || fe_valid !== 1'b1) $display("FAIL parity_err: got perr=%b ins=%h v=%b exp perr=1 ins=%h v=1", par_err, fe_ins, fe_valid, NOP);
    else n_pass++;
    cycle(0, 0, 0, '0, 0, 0);
    n_chk++;
    if (par_err !== 1'b0) $display("FAIL parity_pulse: got perr=%b exp 0", par_err);
    else n_pass++;
    cycle(0, 0, 0, '0, 1, 0);
    n_chk++;
    if (par_err !== 1'b0 || fe_ins !== 16'h1234) $display("FAIL parity_clean: got perr=%b ins=%h exp perr=0 ins=1234", par_err, fe_ins);
    else n_pass++;
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_start_priority();
    test_random();
    test_reset_midload();
`ifdef CODE_MEM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/code_mem.md
CODE_MEM -- requirements
Module: code_mem

Interface
REQ-001 SHALL have parameter INSWIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter PCWIDTH, default 8, fetch address width.
REQ-003 SHALL have parameter DEPTH, default 8, instruction slots (2 <= DEPTH <= 2**PCWIDTH).
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port ld_start  in  1  one-cycle pulse that begins a program load.
REQ-007 SHALL have port ld_valid  in  1  load word present.
REQ-008 SHALL have port ld_last  in  1  qualifies the final load word.
REQ-009 SHALL have port ld_data  in  INSWIDTH  load word.
REQ-010 SHALL have port ld_ready  out  1  load word will be accepted.
REQ-011 SHALL have port fe_req  in  1  fetch request.
REQ-012 SHALL have port fe_pc  in  PCWIDTH  fetch address.
REQ-013 SHALL have port fe_valid  out  1  fetch response valid.
REQ-014 SHALL have port fe_ins  out  INSWIDTH  fetched instruction.
REQ-015 SHALL have port busy  out  1  high while in LOAD.
REQ-016 SHALL have port prog_len  out  PCWIDTH+1  number of loaded instructions.

Function
REQ-017 SHALL implement states EMPTY, LOAD, RUN.
REQ-018 ld_start in any state SHALL enter LOAD next cycle with write pointer 0 and prog_len 0.
REQ-019 In LOAD, ld_ready SHALL equal (wptr < DEPTH); elsewhere ld_ready SHALL be 0.
REQ-020 ld_valid & ld_ready SHALL write ld_data to slot wptr and increment wptr; words offered with ld_ready low are dropped.
REQ-021 An accepted word with ld_last SHALL set prog_len = wptr+1 and enter RUN.
REQ-022 Accepting slot DEPTH-1 without ld_last SHALL set prog_len = DEPTH and enter RUN (full).
REQ-023 ld_start in the same cycle as an accepted word SHALL take priority; the word is discarded.
REQ-024 Fetch latency SHALL be exactly 1 cycle: fe_req at edge N gives fe_valid=1 for cycle N+1 only.
REQ-025 fe_ins SHALL equal slot fe_pc when state was RUN and fe_pc < prog_len at edge N.
REQ-026 Otherwise (EMPTY, LOAD, or fe_pc >= prog_len) fe_ins SHALL be the NOP word {`NOP, `R0, zeros}.
REQ-027 fe_req with ld_start in RUN SHALL return the pre-load contents (state sampled before the transition).
REQ-028 fe_ins SHALL hold its last value when fe_valid is 0.

Reset
REQ-029 rst_n low SHALL immediately force state EMPTY, wptr 0, prog_len 0, fe_valid 0, fe_ins NOP word, ld_ready 0, busy 0.
REQ-030 The instruction array SHALL NOT be reset; stale contents SHALL be unreachable because prog_len = 0.
REQ-031 Reset during LOAD SHALL abandon the load; a new ld_start is required.

Configuration
REQ-032 With CODE_MEM_PARITY_EN defined, each slot SHALL store an even-parity bit computed at write time, and output par_err (1 bit) SHALL pulse with fe_valid when a read slot fails its check, with fe_ins forced to the NOP word.
REQ-033 Without CODE_MEM_PARITY_EN, no parity storage, no par_err port, and no parity logic SHALL exist.

Structure
REQ-034 The NOP opcode, R0 encoding, and NOP word layout SHALL come from the shared definitions file, not be duplicated.
REQ-035 State encoding SHALL be a shared constant set in the same definitions file.
REQ-036 Storage SHALL be one sub-module code_mem_array: 1 write port, 1 registered read port, optional parity bit.

Verification
REQ-037 Load 3 words 0x1111, 0x2222, 0x3333 (ld_last on third) -> prog_len=3, RUN; fetch pc 0,1,2 -> 0x1111, 0x2222, 0x3333 each one cycle later.
REQ-038 After REQ-037, fetch pc=3 and pc=200 -> NOP word, fe_valid=1.
REQ-039 DEPTH=8, stream 10 words without ld_last -> 8 accepted, ld_ready low from 9th, prog_len=8, RUN.
REQ-040 Fetch pc=1 in RUN on the ld_start cycle -> old word; fetch pc=1 during LOAD -> NOP, busy=1.
REQ-041 rst_n low mid-load after 2 words -> all outputs at reset values asynchronously; fetch pc=0 -> NOP.
REQ-042 With CODE_MEM_PARITY_EN, flip a stored bit by force, fetch it -> par_err=1 for one cycle, fe_ins=NOP.
